seq_101_frame_tx: RTL and testbench

//  Serial frame transmitter: takes DATA_W-bit words over a valid/ready handshake and drives them onto a 1-bit line.

---
 rtl/seq_101_frame_tx.sv | 155 +++++++++++++++
 tb/tb_seq_101_frame_tx.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/seq_101_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : seq_101_frame_tx
// Purpose  : Serial "101"-preamble frame transmitter over a valid/ready input.
//            Optional even-parity bit enabled by macro SEQ101_TX_PARITY_EN.
// Revision : 1.0  initial release
// ============================================================================
module seq_101_frame_tx #(
   parameter int DATA_W = 8,
   parameter int GAP    = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              x_out,
   output logic              busy,
   output logic              frame_done
);

   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam int GAP_W = $clog2(GAP + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
   localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PRE_A = 3'd1,
      S_PRE_B = 3'd2,
      S_PRE_C = 3'd3,
      S_DATA  = 3'd4,
      S_GAP   = 3'd5
`ifdef SEQ101_TX_PARITY_EN
      , S_PAR = 3'd6
`endif
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [DATA_W-1:0] shift;
   logic [CNT_W-1:0]  bit_cnt;
   logic [GAP_W-1:0]  gap_cnt;
   logic              accept;

   assign accept = tx_valid && tx_ready;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Counters restart from zero whenever their state is not active,
   // so each one is clear on entry and never needs to wrap.
   always_ff @(posedge clk) begin
      if (reset) begin
         shift   <= '0;
         bit_cnt <= '0;
         gap_cnt <= '0;
      end else begin
         bit_cnt <= '0;
         gap_cnt <= '0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  shift <= tx_data;
               end
            end
            S_DATA: begin
               shift   <= {shift[DATA_W-2:0], 1'b0};
               bit_cnt <= bit_cnt + CNT_W'(1);
            end
            S_GAP: begin
               gap_cnt <= gap_cnt + GAP_W'(1);
            end
            default: begin
            end
         endcase
      end
   end

`ifdef SEQ101_TX_PARITY_EN
   logic parity;

   // Running XOR of the bits already driven onto the line.
   always_ff @(posedge clk) begin
      if (reset) begin
         parity <= 1'b0;
      end else if (state == S_IDLE && accept) begin
         parity <= 1'b0;
      end else if (state == S_DATA) begin
         parity <= parity ^ shift[DATA_W-1];
      end
   end
`endif

   always_comb begin
      state_nxt  = state;
      x_out      = 1'b0;
      busy       = 1'b1;
      tx_ready   = 1'b0;
      frame_done = 1'b0;
      case (state)
         S_IDLE: begin
            busy     = 1'b0;
            tx_ready = !reset;
            if (tx_valid && !reset) begin
               state_nxt = S_PRE_A;
            end
         end
         S_PRE_A: begin
            x_out     = 1'b1;
            state_nxt = S_PRE_B;
         end
         S_PRE_B: begin
            state_nxt = S_PRE_C;
         end
         S_PRE_C: begin
            x_out     = 1'b1;
            state_nxt = S_DATA;
         end
         S_DATA: begin
            x_out = shift[DATA_W-1];
            if (bit_cnt == LAST_BIT) begin
`ifdef SEQ101_TX_PARITY_EN
               state_nxt = S_PAR;
`else
               state_nxt = S_GAP;
`endif
            end
         end
`ifdef SEQ101_TX_PARITY_EN
         S_PAR: begin
            x_out     = parity;
            state_nxt = S_GAP;
         end
`endif
         S_GAP: begin
            frame_done = (gap_cnt == '0);
            if (gap_cnt == LAST_GAP) begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_seq_101_frame_tx.sv
`default_nettype none
// Directed self-checking bench for seq_101_frame_tx (DATA_W=8, GAP=2).
module tb_seq_101_frame_tx;

   localparam int DATA_W = 8;
   localparam int GAP    = 2;
`ifdef SEQ101_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int NBITS  = 3 + DATA_W + P;
   localparam int PERIOD = 1 + NBITS + GAP;

   logic       clk      = 1'b0;
   logic       reset    = 1'b1;
   logic       tx_valid = 1'b1;
   logic [7:0] tx_data  = 8'h5A;
   logic       tx_ready;
   logic       x_out;
   logic       busy;
   logic       frame_done;

   int n_cmp = 0;
   int n_err = 0;

   seq_101_frame_tx #(.DATA_W(DATA_W), .GAP(GAP)) dut (
      .clk        (clk),
      .reset      (reset),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .x_out      (x_out),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Line value expected i cycles after the accepting edge (i=0 is the first preamble bit).
   function automatic logic exp_bit(input logic [7:0] w, input int i);
      if (i < 3)              return (i != 1);
      else if (i < 3 + 8)     return w[10-i];
      else if (i < 3 + 8 + P) return ^w;
      else                    return 1'b0;
   endfunction

   // Starts one cycle after accept; ends in the first IDLE cycle.
   task automatic check_frame(input logic [7:0] w, input string tag, input bit disturb);
      for (int i = 0; i < NBITS; i++) begin
         chk({tag, "_x"}, x_out, exp_bit(w, i));
         chk({tag, "_busy"}, busy, 1'b1);
         chk({tag, "_rdy"}, tx_ready, 1'b0);
         chk({tag, "_fd"}, frame_done, 1'b0);
         if (disturb) begin
            tx_valid = ~tx_valid;
            tx_data  = 8'($urandom);
         end
         tick();
      end
      for (int g = 0; g < GAP; g++) begin
         chk({tag, "_gapx"}, x_out, 1'b0);
         chk({tag, "_gapfd"}, frame_done, (g == 0));
         chk({tag, "_gaprdy"}, tx_ready, 1'b0);
         if (disturb) begin
            tx_valid = ~tx_valid;
            tx_data  = 8'($urandom);
         end
         tick();
      end
      if (disturb) tx_valid = 1'b0;
      chk({tag, "_endrdy"}, tx_ready, 1'b1);
      chk({tag, "_endbusy"}, busy, 1'b0);
      chk({tag, "_endx"}, x_out, 1'b0);
   endtask

   task automatic send(input logic [7:0] w, input string tag, input bit disturb);
      tx_data  = w;
      tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      check_frame(w, tag, disturb);
   endtask

   initial begin
      // 1. reset held with tx_valid high
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_x", x_out, 1'b0);
         chk("rst_busy", busy, 1'b0);
         chk("rst_rdy", tx_ready, 1'b0);
         chk("rst_fd", frame_done, 1'b0);
      end
      reset    = 1'b0;
      tx_valid = 1'b0;
      #1;
      chk("rel_rdy", tx_ready, 1'b1);
      tick();
      chk("idle_busy", busy, 1'b0);

      // 2, 3. single frames
      send(8'hA5, "a5", 1'b0);
      send(8'h01, "w01", 1'b0);

      // 4. back-to-back with tx_valid held
      tx_data  = 8'hFF;
      tx_valid = 1'b1;
      tick();
      tx_data = 8'h00;
      check_frame(8'hFF, "ff", 1'b0);
      tick();
      tx_valid = 1'b0;
      check_frame(8'h00, "w00", 1'b0);

      // reset and accept on the same edge: word dropped
      reset    = 1'b1;
      tx_valid = 1'b1;
      tx_data  = 8'hE7;
      tick();
      chk("rstacc_busy", busy, 1'b0);
      chk("rstacc_x", x_out, 1'b0);
      reset    = 1'b0;
      tx_valid = 1'b0;
      tick();
      chk("rstacc_busy2", busy, 1'b0);
      chk("rstacc_x2", x_out, 1'b0);

      // 5. abort during 3rd payload bit
      tx_data  = 8'hC3;
      tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) tick();
         chk("c3_x", x_out, exp_bit(8'hC3, i));
      end
      reset = 1'b1;
      tick();
      chk("abort_x", x_out, 1'b0);
      chk("abort_busy", busy, 1'b0);
      chk("abort_fd", frame_done, 1'b0);
      chk("abort_rdy", tx_ready, 1'b0);
      reset = 1'b0;
      #1;
      chk("abort_relrdy", tx_ready, 1'b1);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("abort_fd_quiet", frame_done, 1'b0);
         chk("abort_x_quiet", x_out, 1'b0);
      end
      send(8'h3C, "w3c", 1'b0);

      // 6. inputs disturbed mid-frame
      send(8'h96, "w96", 1'b1);
      tick();
      chk("post_busy", busy, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
